fpga_tx_com_param: RTL and testbench

Parametrised serial frame transmitter for the FPGA slave link. It shifts NWORDS words of WBITS bits each out on a single line, MSB first, one bit per sync_tx tick. An optional start marker and an optional per-word parity bit can be added to the frame. It replaces the fixed 3x4-bit transmitter and keeps the same start_tx / ready_tx / sync_tx handshake toward the link controller.

---
 rtl/fpga_tx_com_param.sv | 126 ++++++++++++
 tb/tb_fpga_tx_com_param.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/fpga_tx_com_param.sv
// Serial frame transmitter: optional start marker, NWORDS words of WBITS bits
// sent MSB first with optional per-word parity, one slot per sync_tx tick.
module fpga_tx_com_param #(
  parameter int NWORDS     = 3,
  parameter int WBITS      = 4,
  parameter int START_BIT  = 1,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    sync_tx,
  input  logic                    start_tx,
  input  logic [NWORDS*WBITS-1:0] words_in,
  output logic                    tx,
  output logic                    busy_tx,
  output logic                    ready_tx
);

  localparam int WW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int BW = (WBITS > 1) ? $clog2(WBITS) : 1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_DONE} state_t;

  state_t                         state_q, state_d;
  logic [NWORDS-1:0][WBITS-1:0]   words_q, words_d;
  logic [WBITS-1:0]               sh_q, sh_d;
  logic [WW-1:0]                  widx_q, widx_d, widx_nxt;
  logic [BW-1:0]                  bidx_q, bidx_d;
  logic                           tx_q, tx_d;
  logic                           last_word, last_bit;

  assign widx_nxt  = widx_q + WW'(1);
  assign last_word = (widx_q == WW'(NWORDS - 1));
  assign last_bit  = (bidx_q == BW'(WBITS - 1));

  always_comb begin
    state_d = state_q;
    words_d = words_q;
    sh_d    = sh_q;
    widx_d  = widx_q;
    bidx_d  = bidx_q;
    tx_d    = tx_q;
    unique case (state_q)
      S_IDLE: begin
        // A tick coinciding with acceptance only idles the line.
        if (sync_tx) tx_d = 1'b0;
        if (start_tx) begin
          words_d = words_in;
          sh_d    = words_in[WBITS-1:0];
          widx_d  = '0;
          bidx_d  = '0;
          state_d = (START_BIT != 0) ? S_START : S_DATA;
        end
      end
      S_START: begin
        if (sync_tx) begin
          tx_d    = 1'b1;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (sync_tx) begin
          tx_d   = sh_q[WBITS-1];
          sh_d   = sh_q << 1;
          bidx_d = bidx_q + BW'(1);
          if (last_bit) begin
            bidx_d = '0;
            if (PARITY_EN != 0) begin
              state_d = S_PAR;
            end else if (last_word) begin
              state_d = S_DONE;
            end else begin
              widx_d = widx_nxt;
              sh_d   = words_q[widx_nxt];
            end
          end
        end
      end
      S_PAR: begin
        if (sync_tx) begin
          // Parity covers the latched word, not the shifted copy.
          tx_d = (^words_q[widx_q]) ^ (PARITY_ODD != 0);
          if (last_word) begin
            state_d = S_DONE;
          end else begin
            widx_d  = widx_nxt;
            bidx_d  = '0;
            sh_d    = words_q[widx_nxt];
            state_d = S_DATA;
          end
        end
      end
      S_DONE: begin
        if (sync_tx) begin
          tx_d    = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      words_q <= '0;
      sh_q    <= '0;
      widx_q  <= '0;
      bidx_q  <= '0;
      tx_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      words_q <= words_d;
      sh_q    <= sh_d;
      widx_q  <= widx_d;
      bidx_q  <= bidx_d;
      tx_q    <= tx_d;
    end
  end

  assign tx       = tx_q;
  assign busy_tx  = (state_q == S_START) || (state_q == S_DATA) || (state_q == S_PAR);
  assign ready_tx = (state_q == S_DONE);

endmodule

// File: tb/tb_fpga_tx_com_param.sv
// Directed bench: default, even/odd parity and 1x1 configurations run side by
// side on shared clock/tick/start; each slot compared to hand-derived vectors.
module tb_fpga_tx_com_param;

  logic        clk = 1'b0;
  logic        reset, sync_tx, start_tx;
  logic [11:0] w0, w1, w2;
  logic [0:0]  w3;
  logic        tx0, tx1, tx2, tx3;
  logic        bz0, bz1, bz2, bz3;
  logic        rd0, rd1, rd2, rd3;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  fpga_tx_com_param dut0 (
    .clk(clk), .reset(reset), .sync_tx(sync_tx), .start_tx(start_tx),
    .words_in(w0), .tx(tx0), .busy_tx(bz0), .ready_tx(rd0));

  fpga_tx_com_param #(.PARITY_EN(1), .PARITY_ODD(0)) dut1 (
    .clk(clk), .reset(reset), .sync_tx(sync_tx), .start_tx(start_tx),
    .words_in(w1), .tx(tx1), .busy_tx(bz1), .ready_tx(rd1));

  fpga_tx_com_param #(.PARITY_EN(1), .PARITY_ODD(1)) dut2 (
    .clk(clk), .reset(reset), .sync_tx(sync_tx), .start_tx(start_tx),
    .words_in(w2), .tx(tx2), .busy_tx(bz2), .ready_tx(rd2));

  fpga_tx_com_param #(.NWORDS(1), .WBITS(1), .START_BIT(0)) dut3 (
    .clk(clk), .reset(reset), .sync_tx(sync_tx), .start_tx(start_tx),
    .words_in(w3), .tx(tx3), .busy_tx(bz3), .ready_tx(rd3));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One tick: sync_tx high for one clock, then 3 idle clocks (period of 4).
  // Outputs are sampled on the negedge right after the ticking posedge.
  task automatic tick();
    @(negedge clk) sync_tx = 1'b1;
    @(negedge clk) sync_tx = 1'b0;
  endtask

  task automatic gap();
    repeat (2) @(negedge clk);
  endtask

  task automatic start_pulse();
    @(negedge clk) start_tx = 1'b1;
    @(negedge clk) start_tx = 1'b0;
  endtask

  // Ticks t = from..17 on dut0, checking tx against e[t]; ready at tick rdy_t.
  task automatic run0(input string tag, input logic [1:17] e, input int from, input int rdy_t);
    for (int t = from; t <= 17; t++) begin
      tick();
      chk($sformatf("%s_tx_t%0d", tag, t), {31'd0, tx0}, {31'd0, e[t]});
      chk($sformatf("%s_rdy_t%0d", tag, t), {31'd0, rd0}, {31'd0, t == rdy_t});
      gap();
    end
  endtask

  logic [1:17] e0, e1, e2, e3, e5;

  initial begin
    // F3A: marker, 1010, 0011, 1111
    e0 = 17'b1_1010_0011_1111_0000;
    // 537 even: marker, 0111 1, 0011 0, 0101 0
    e1 = 17'b1_01111_00110_01010_0;
    // 537 odd: parity slots 0, 1, 1
    e2 = 17'b1_01110_00111_01011_0;
    e3 = 17'b1_0000_0000_0000_0000;
    // 5C9: marker, 1001, 1100, 0101
    e5 = 17'b1_1001_1100_0101_0000;

    reset = 1'b1; sync_tx = 1'b0; start_tx = 1'b0;
    w0 = 12'hF3A; w1 = 12'h537; w2 = 12'h537; w3 = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_tx0", {31'd0, tx0}, 32'd0);
    chk("rst_busy0", {31'd0, bz0}, 32'd0);
    chk("rst_rdy0", {31'd0, rd0}, 32'd0);
    chk("rst_busy3", {31'd0, bz3}, 32'd0);

    // All four configurations in parallel.
    start_pulse();
    chk("acc_busy0", {31'd0, bz0}, 32'd1);
    chk("acc_busy3", {31'd0, bz3}, 32'd1);
    chk("acc_tx0", {31'd0, tx0}, 32'd0);
    w0 = 12'h000; w1 = 12'h000; w2 = 12'h000; w3 = 1'b0;
    for (int t = 1; t <= 17; t++) begin
      tick();
      chk($sformatf("def_tx_t%0d", t), {31'd0, tx0}, {31'd0, e0[t]});
      chk($sformatf("def_rdy_t%0d", t), {31'd0, rd0}, {31'd0, t == 13});
      chk($sformatf("def_busy_t%0d", t), {31'd0, bz0}, {31'd0, t < 13});
      chk($sformatf("pe_tx_t%0d", t), {31'd0, tx1}, {31'd0, e1[t]});
      chk($sformatf("pe_rdy_t%0d", t), {31'd0, rd1}, {31'd0, t == 16});
      chk($sformatf("po_tx_t%0d", t), {31'd0, tx2}, {31'd0, e2[t]});
      chk($sformatf("po_rdy_t%0d", t), {31'd0, rd2}, {31'd0, t == 16});
      chk($sformatf("one_tx_t%0d", t), {31'd0, tx3}, {31'd0, e3[t]});
      chk($sformatf("one_rdy_t%0d", t), {31'd0, rd3}, {31'd0, t == 1});
      chk($sformatf("one_busy_t%0d", t), {31'd0, bz3}, 32'd0);
      chk($sformatf("excl_t%0d", t), {31'd0, bz0 & rd0}, 32'd0);
      gap();
    end

    // Start coincident with a tick; later start mid-frame must be ignored.
    w0 = 12'hF3A;
    @(negedge clk) begin start_tx = 1'b1; sync_tx = 1'b1; end
    @(negedge clk) begin start_tx = 1'b0; sync_tx = 1'b0; end
    chk("same_tx", {31'd0, tx0}, 32'd0);
    chk("same_busy", {31'd0, bz0}, 32'd1);
    w0 = 12'h000;
    run0("same", e0, 1, 13);
    w0 = 12'hF3A;
    start_pulse();
    for (int t = 1; t <= 3; t++) begin
      tick();
      chk($sformatf("ign_tx_t%0d", t), {31'd0, tx0}, {31'd0, e0[t]});
      gap();
    end
    w0 = 12'h0F0;
    start_pulse();
    run0("ign", e0, 4, 13);

    // Reset lands on the 6th tick.
    w0 = 12'hF3A;
    start_pulse();
    for (int t = 1; t <= 5; t++) begin
      tick();
      chk($sformatf("pre_rst_tx_t%0d", t), {31'd0, tx0}, {31'd0, e0[t]});
      gap();
    end
    @(negedge clk) begin reset = 1'b1; sync_tx = 1'b1; end
    @(negedge clk) begin reset = 1'b0; sync_tx = 1'b0; end
    chk("mid_rst_tx", {31'd0, tx0}, 32'd0);
    chk("mid_rst_busy", {31'd0, bz0}, 32'd0);
    chk("mid_rst_rdy", {31'd0, rd0}, 32'd0);
    w0 = 12'h5C9;
    start_pulse();
    run0("post_rst", e5, 1, 13);

    // Freeze for 50 clocks with no tick mid-frame.
    w0 = 12'hF3A;
    start_pulse();
    for (int t = 1; t <= 4; t++) begin
      tick();
      gap();
    end
    repeat (50) @(negedge clk);
    chk("frz_tx", {31'd0, tx0}, {31'd0, e0[4]});
    chk("frz_busy", {31'd0, bz0}, 32'd1);
    chk("frz_rdy", {31'd0, rd0}, 32'd0);
    run0("frz", e0, 5, 13);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
